store_pack_buffer: RTL and testbench

//  Store-side counterpart of the load/immediate extender: narrows a 32-bit register

---
 rtl/store_pack_buffer.sv | 146 ++++++++++++++
 tb/tb_store_pack_buffer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/store_pack_buffer.sv
// Store packer plus two-entry store buffer between the MEM stage and data memory.
// Optional feature: define MISALIGN_TRAP_EN to drop misaligned half/word stores and flag them.
module store_pack_buffer #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_data,
    input  logic [1:0]       req_size,
    output logic             mem_valid,
    input  logic             mem_ready,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_be,
    output logic [CNT_W-1:0] store_count,
    output logic             misalign_err
);

    logic [1:0]       count_reg, count_next;
    logic             wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [31:0]      ent_addr_reg  [DEPTH];
    logic [31:0]      ent_wdata_reg [DEPTH];
    logic [3:0]       ent_be_reg    [DEPTH];
    logic [31:0]      mem_addr_reg, mem_wdata_reg;
    logic [3:0]       mem_be_reg;
    logic [CNT_W-1:0] store_count_reg;
    logic             misalign_err_reg;

    logic [31:0]      pk_addr, pk_wdata;
    logic [3:0]       pk_be;
    logic             misaligned;
    logic             accept, complete, wr_en, head_from_input;

    always_comb begin
        pk_addr  = {req_addr[31:2], 2'b00};
        pk_wdata = req_data;
        pk_be    = 4'b1111;
        case (req_size)
            2'b00: begin
                pk_be    = 4'b0001 << req_addr[1:0];
                pk_wdata = {4{req_data[7:0]}};
            end
            2'b01: begin
                pk_be    = req_addr[1] ? 4'b1100 : 4'b0011;
                pk_wdata = {2{req_data[15:0]}};
            end
            default: begin
                pk_be    = 4'b1111;
                pk_wdata = req_data;
            end
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    // Size 2'b11 is handled as a word, so size[1] covers both word encodings.
    assign misaligned = (req_size == 2'b01 && req_addr[0]) ||
                        (req_size[1] && req_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign req_ready = (count_reg != 2'd2);
    assign mem_valid = (count_reg != 2'd0);
    assign accept    = req_valid && req_ready;
    assign complete  = mem_valid && mem_ready;
    assign wr_en     = accept && !misaligned;

    always_comb begin
        count_next  = count_reg;
        rd_ptr_next = rd_ptr_reg;
        case ({wr_en, complete})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
        if (complete)
            rd_ptr_next = ~rd_ptr_reg;
        // The new head is the store being written this cycle when it lands on the next read slot.
        head_from_input = wr_en && (wr_ptr_reg == rd_ptr_next);
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ent_addr_reg[gi]  <= '0;
                    ent_wdata_reg[gi] <= '0;
                    ent_be_reg[gi]    <= '0;
                end else if (wr_en && (wr_ptr_reg == gi[0])) begin
                    ent_addr_reg[gi]  <= pk_addr;
                    ent_wdata_reg[gi] <= pk_wdata;
                    ent_be_reg[gi]    <= pk_be;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg        <= '0;
            wr_ptr_reg       <= 1'b0;
            rd_ptr_reg       <= 1'b0;
            mem_addr_reg     <= '0;
            mem_wdata_reg    <= '0;
            mem_be_reg       <= '0;
            store_count_reg  <= '0;
            misalign_err_reg <= 1'b0;
        end else begin
            count_reg  <= count_next;
            rd_ptr_reg <= rd_ptr_next;
            if (wr_en)
                wr_ptr_reg <= ~wr_ptr_reg;
            if (complete)
                store_count_reg <= store_count_reg + CNT_W'(1);
            if (accept && misaligned)
                misalign_err_reg <= 1'b1;
            // Output registers track the head; when the buffer drains they keep the last head.
            if (count_next != 2'd0) begin
                if (head_from_input) begin
                    mem_addr_reg  <= pk_addr;
                    mem_wdata_reg <= pk_wdata;
                    mem_be_reg    <= pk_be;
                end else begin
                    mem_addr_reg  <= ent_addr_reg[rd_ptr_next];
                    mem_wdata_reg <= ent_wdata_reg[rd_ptr_next];
                    mem_be_reg    <= ent_be_reg[rd_ptr_next];
                end
            end
        end
    end

    assign mem_addr     = mem_addr_reg;
    assign mem_wdata    = mem_wdata_reg;
    assign mem_be       = mem_be_reg;
    assign store_count  = store_count_reg;
`ifdef MISALIGN_TRAP_EN
    assign misalign_err = misalign_err_reg;
`else
    assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_store_pack_buffer.sv
// Directed testbench for store_pack_buffer: packing, backpressure, overlap, async reset, misalignment.
module tb_store_pack_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [31:0] req_addr, req_data;
    logic [1:0]  req_size;
    logic        mem_valid, mem_ready;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] store_count;
    logic        misalign_err;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [31:0] exp_sc = 0;

    always #5 clk = ~clk;

    store_pack_buffer #(.DEPTH(2), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .store_count(store_count), .misalign_err(misalign_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        req_valid = v;
        req_addr  = a;
        req_data  = d;
        req_size  = s;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        #12;
        tests_run++;
        if ({mem_valid, mem_addr, mem_wdata, mem_be, misalign_err} !== 70'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: valid=%b addr=%h wdata=%h be=%b err=%b required all zero",
                     mem_valid, mem_addr, mem_wdata, mem_be, misalign_err);
        end
        tests_run++;
        if (store_count !== 32'd0 || req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_count_ready: store_count=%0d ready=%b required 0/1", store_count, req_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();
        $display("[TB] reset released");
    endtask

    task automatic test_packing();
        logic [31:0] va [6] = '{32'h1003, 32'h2002, 32'h0001, 32'h2000, 32'h600C, 32'h7008};
        logic [31:0] vd [6] = '{32'hAABBCCDD, 32'h12345678, 32'h000000A5, 32'hCAFEBEEF, 32'h01234567, 32'h89ABCDEF};
        logic [1:0]  vs [6] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b11, 2'b10};
        logic [31:0] ea [6] = '{32'h1000, 32'h2000, 32'h0000, 32'h2000, 32'h600C, 32'h7008};
        logic [3:0]  eb [6] = '{4'b1000, 4'b1100, 4'b0010, 4'b0011, 4'b1111, 4'b1111};
        logic [31:0] ew [6] = '{32'hDDDDDDDD, 32'h56785678, 32'hA5A5A5A5, 32'hBEEFBEEF, 32'h01234567, 32'h89ABCDEF};
        mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, va[i], vd[i], vs[i]);
            step();
            drive(1'b0, 32'h0, 32'h0, 2'b00);
            tests_run++;
            if (mem_valid !== 1'b1 || mem_addr !== ea[i] || mem_be !== eb[i] || mem_wdata !== ew[i]) begin
                tests_failed++;
                $display("FAIL pack_%0d: valid=%b addr=%h be=%b wdata=%h required 1 %h %b %h",
                         i, mem_valid, mem_addr, mem_be, mem_wdata, ea[i], eb[i], ew[i]);
            end
            step();
            exp_sc++;
            tests_run++;
            if (store_count !== exp_sc || mem_valid !== 1'b0 || mem_addr !== ea[i]) begin
                tests_failed++;
                $display("FAIL pack_done_%0d: store_count=%0d valid=%b addr=%h required %0d 0 %h (held)",
                         i, store_count, mem_valid, mem_addr, exp_sc, ea[i]);
            end
            $display("[TB] pack %0d addr=%h size=%b -> be=%b wdata=%h", i, va[i], vs[i], mem_be, mem_wdata);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] order [3] = '{32'h4000, 32'h4004, 32'h4008};
        mem_ready = 1'b0;
        drive(1'b1, 32'h4000, 32'h11111111, 2'b10);
        step();
        drive(1'b1, 32'h4004, 32'h22222222, 2'b10);
        step();
        drive(1'b1, 32'h4008, 32'h33333333, 2'b10);
        tests_run++;
        if (req_ready !== 1'b0 || mem_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_full: ready=%b valid=%b required 0/1", req_ready, mem_valid);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            tests_run++;
            if (mem_addr !== 32'h4000 || mem_wdata !== 32'h11111111 || mem_be !== 4'b1111 || req_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_stable_%0d: addr=%h wdata=%h be=%b ready=%b required 4000 11111111 1111 0",
                         c, mem_addr, mem_wdata, mem_be, req_ready);
            end
        end
        mem_ready = 1'b1;
        step();
        tests_run++;
        if (mem_addr !== order[1] || mem_wdata !== 32'h22222222 || req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_drain_1: addr=%h wdata=%h ready=%b required %h 22222222 1", mem_addr, mem_wdata, req_ready, order[1]);
        end
        step();
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        tests_run++;
        if (mem_valid !== 1'b1 || mem_addr !== order[2] || mem_wdata !== 32'h33333333) begin
            tests_failed++;
            $display("FAIL bp_drain_2: valid=%b addr=%h wdata=%h required 1 %h 33333333", mem_valid, mem_addr, mem_wdata, order[2]);
        end
        step();
        exp_sc += 3;
        tests_run++;
        if (mem_valid !== 1'b0 || store_count !== exp_sc) begin
            tests_failed++;
            $display("FAIL bp_empty: valid=%b store_count=%0d required 0 %0d", mem_valid, store_count, exp_sc);
        end
        $display("[TB] backpressure three words drained, store_count=%0d", store_count);
    endtask

    task automatic test_simultaneous();
        mem_ready = 1'b0;
        drive(1'b1, 32'h5000, 32'hAAAA0000, 2'b10);
        step();
        mem_ready = 1'b1;
        drive(1'b1, 32'h5006, 32'h0000BBBB, 2'b01);
        step();
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        exp_sc++;
        tests_run++;
        if (mem_valid !== 1'b1 || req_ready !== 1'b1 || mem_addr !== 32'h5004 ||
            mem_be !== 4'b1100 || mem_wdata !== 32'hBBBBBBBB || store_count !== exp_sc) begin
            tests_failed++;
            $display("FAIL simul: valid=%b ready=%b addr=%h be=%b wdata=%h sc=%0d required 1 1 5004 1100 bbbbbbbb %0d",
                     mem_valid, req_ready, mem_addr, mem_be, mem_wdata, store_count, exp_sc);
        end
        step();
        exp_sc++;
        tests_run++;
        if (mem_valid !== 1'b0 || store_count !== exp_sc) begin
            tests_failed++;
            $display("FAIL simul_drain: valid=%b sc=%0d required 0 %0d", mem_valid, store_count, exp_sc);
        end
        $display("[TB] simultaneous accept+complete, store_count=%0d", store_count);
    endtask

    task automatic test_reset_midop();
        mem_ready = 1'b0;
        drive(1'b1, 32'h8000, 32'h12121212, 2'b10);
        step();
        drive(1'b1, 32'h8004, 32'h34343434, 2'b10);
        step();
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        #2;
        rst_n = 1'b0;
        #1;
        exp_sc = 0;
        tests_run++;
        if (mem_valid !== 1'b0 || store_count !== 32'd0 || req_ready !== 1'b1 || mem_addr !== 32'h0) begin
            tests_failed++;
            $display("FAIL async_reset: valid=%b sc=%0d ready=%b addr=%h required 0 0 1 0",
                     mem_valid, store_count, req_ready, mem_addr);
        end
        #3;
        rst_n = 1'b1;
        mem_ready = 1'b1;
        step();
        tests_run++;
        if (mem_valid !== 1'b0 || store_count !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_discard: valid=%b sc=%0d required 0 0", mem_valid, store_count);
        end
        $display("[TB] reset mid-operation discarded buffered entries");
    endtask

    task automatic test_misalign();
        mem_ready = 1'b1;
        drive(1'b1, 32'h3001, 32'hDEADBEEF, 2'b10);
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL mis_ready: ready=%b required 1", req_ready);
        end
        step();
        drive(1'b0, 32'h0, 32'h0, 2'b00);
`ifdef MISALIGN_TRAP_EN
        tests_run++;
        if (mem_valid !== 1'b0 || misalign_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL mis_trap: valid=%b err=%b required 0 1", mem_valid, misalign_err);
        end
        drive(1'b1, 32'h3004, 32'h0F0F0F0F, 2'b10);
        step();
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        step();
        exp_sc++;
        tests_run++;
        if (misalign_err !== 1'b1 || store_count !== exp_sc) begin
            tests_failed++;
            $display("FAIL mis_sticky: err=%b sc=%0d required 1 %0d", misalign_err, store_count, exp_sc);
        end
`else
        tests_run++;
        if (mem_valid !== 1'b1 || mem_be !== 4'b1111 || mem_addr !== 32'h3000 ||
            mem_wdata !== 32'hDEADBEEF || misalign_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL mis_ignored: valid=%b be=%b addr=%h wdata=%h err=%b required 1 1111 3000 deadbeef 0",
                     mem_valid, mem_be, mem_addr, mem_wdata, misalign_err);
        end
        step();
        exp_sc++;
        tests_run++;
        if (store_count !== exp_sc || misalign_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL mis_count: sc=%0d err=%b required %0d 0", store_count, misalign_err, exp_sc);
        end
`endif
        $display("[TB] misaligned word at 0x3001 err=%b store_count=%0d", misalign_err, store_count);
    endtask

    initial begin
        test_reset();
        test_packing();
        test_backpressure();
        test_simultaneous();
        test_reset_midop();
        test_misalign();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
